// File: rtl/noise_est_pkg.sv
// Shared types and default sizing for the frame noise estimator.
// Build option: define NOISE_MIN_VAR_EN to report the minimum block variance instead of the average.
package noise_est_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    BLOCK_VAR,
    DIVIDE,
    DONE
  } state_e;

  localparam int DW_DEFAULT = 8;
  localparam int N_DEFAULT  = 4;
  localparam int LOG2_N     = $clog2(N_DEFAULT);
  localparam int BPF_WIDTH  = 32;

endpackage

// File: rtl/block_variance_unit.sv
// Accumulates sum and sum of squares of one block and presents its population variance.
module block_variance_unit
  import noise_est_pkg::*;
#(
  parameter int DATA_WIDTH    = DW_DEFAULT,
  parameter int TOTAL_SAMPLES = N_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    acc_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [2*DATA_WIDTH-1:0] var_o
);

  localparam int L   = $clog2(TOTAL_SAMPLES);
  localparam int SW  = DATA_WIDTH + L;
  localparam int SQW = 2*DATA_WIDTH + L;

  logic [SW-1:0]           sum_q, sum_d;
  logic [SQW-1:0]          sumsq_q, sumsq_d;
  logic [2*DATA_WIDTH-1:0] dataWide, dataSq, meanWide, meanSq, sqMean;
  logic [DATA_WIDTH-1:0]   mean;

  // load_i restarts the block with the strobe-cycle sample so no separate clear is needed.
  always_comb begin
    dataWide = {{DATA_WIDTH{1'b0}}, data_i};
    dataSq   = dataWide * dataWide;
    sum_d    = sum_q;
    sumsq_d  = sumsq_q;
    if (load_i) begin
      sum_d   = {{L{1'b0}}, data_i};
      sumsq_d = {{L{1'b0}}, dataSq};
    end else if (acc_i) begin
      sum_d   = sum_q + {{L{1'b0}}, data_i};
      sumsq_d = sumsq_q + {{L{1'b0}}, dataSq};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      sumsq_q <= '0;
    end else begin
      sum_q   <= sum_d;
      sumsq_q <= sumsq_d;
    end
  end

  always_comb begin
    mean     = sum_q[SW-1:L];
    meanWide = {{DATA_WIDTH{1'b0}}, mean};
    meanSq   = meanWide * meanWide;
    sqMean   = sumsq_q[SQW-1:L];
    var_o    = (sqMean >= meanSq) ? (sqMean - meanSq) : '0;
  end

endmodule

// File: rtl/noise_estimation_top.sv
// Frame noise estimator: averages block variances over a frame with a bit-serial divider.
// Build option: NOISE_MIN_VAR_EN selects the minimum block variance instead (no divider used).
module noise_estimation_top
  import noise_est_pkg::*;
#(
  parameter int DATA_WIDTH    = DW_DEFAULT,
  parameter int TOTAL_SAMPLES = N_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_of_frame,
  input  logic                    end_of_frame,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    start_data,
  input  logic [BPF_WIDTH-1:0]    blocks_per_frame,
  output logic [2*DATA_WIDTH-1:0] estimated_noise,
  output logic                    estimated_noise_ready
);

  localparam int LOG2N = $clog2(TOTAL_SAMPLES);
  localparam int EW    = 2*DATA_WIDTH;
  localparam int AW    = EW + BPF_WIDTH;
  localparam int CW    = LOG2N + 1;
  localparam int DCW   = $clog2(AW);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sof_q, sof_d, eof_q, eof_d;
  logic [AW-1:0]      acc_q, acc_d, quo_q, quo_d;
  logic [BPF_WIDTH:0] rem_q, rem_d;
  logic [DCW-1:0]     divCnt_q, divCnt_d;
  logic [EW-1:0]      est_q, est_d;
  logic               ready_q, ready_d;
  logic [EW-1:0]      min_q, min_d;

  logic               bvLoad, bvAcc;
  logic [EW-1:0]      blockVar, minNext;
  logic [AW-1:0]      newAcc, quoNext;
  logic [BPF_WIDTH:0] remShift, remNext;
  logic               quoBit;

  block_variance_unit #(
    .DATA_WIDTH   (DATA_WIDTH),
    .TOTAL_SAMPLES(TOTAL_SAMPLES)
  ) u_bvu (
    .clk   (clk),
    .rst   (rst),
    .load_i(bvLoad),
    .acc_i (bvAcc),
    .data_i(data_in),
    .var_o (blockVar)
  );

  // One restoring-division step per DIVIDE cycle: dividend bits shift out of quo_q as quotient bits shift in.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sof_d    = sof_q;
    eof_d    = eof_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    divCnt_d = divCnt_q;
    est_d    = est_q;
    ready_d  = 1'b0;
    min_d    = min_q;
    bvLoad   = 1'b0;
    bvAcc    = 1'b0;

    newAcc   = (sof_q ? '0 : acc_q) + {{BPF_WIDTH{1'b0}}, blockVar};
    minNext  = (sof_q || (blockVar < min_q)) ? blockVar : min_q;
    remShift = {rem_q[BPF_WIDTH-1:0], quo_q[AW-1]};
    quoBit   = (remShift >= {1'b0, blocks_per_frame});
    remNext  = quoBit ? (remShift - {1'b0, blocks_per_frame}) : remShift;
    quoNext  = {quo_q[AW-2:0], quoBit};

    case (state_q)
      IDLE: begin
        if (start_data) begin
          bvLoad  = 1'b1;
          sof_d   = start_of_frame;
          eof_d   = end_of_frame;
          cnt_d   = CW'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        bvAcc = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(TOTAL_SAMPLES - 1)) state_d = BLOCK_VAR;
      end
      BLOCK_VAR: begin
        sof_d   = 1'b0;
        state_d = IDLE;
`ifdef NOISE_MIN_VAR_EN
        min_d = minNext;
        if (eof_q) begin
          est_d   = minNext;
          ready_d = 1'b1;
          state_d = DONE;
        end
`else
        acc_d = newAcc;
        if (eof_q) begin
          quo_d    = newAcc;
          rem_d    = '0;
          divCnt_d = '0;
          state_d  = DIVIDE;
        end
`endif
      end
      DIVIDE: begin
        quo_d    = quoNext;
        rem_d    = remNext;
        divCnt_d = divCnt_q + DCW'(1);
        if (divCnt_q == DCW'(AW - 1)) begin
          ready_d = 1'b1;
          state_d = DONE;
          if (blocks_per_frame == '0) est_d = '0;
          else if (|quoNext[AW-1:EW]) est_d = '1;
          else est_d = quoNext[EW-1:0];
        end
      end
      DONE: begin
        acc_d   = '0;
        min_d   = '1;
        eof_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      acc_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      divCnt_q <= '0;
      est_q    <= '0;
      ready_q  <= 1'b0;
      min_q    <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      divCnt_q <= divCnt_d;
      est_q    <= est_d;
      ready_q  <= ready_d;
      min_q    <= min_d;
    end
  end

  assign estimated_noise       = est_q;
  assign estimated_noise_ready = ready_q;

endmodule

// File: tb/tb_noise_estimation_top.sv
// Randomised and directed bench for noise_estimation_top against an arithmetic frame model.
module tb_noise_estimation_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_of_frame = 1'b0;
  logic        end_of_frame = 1'b0;
  logic        start_data = 1'b0;
  logic [7:0]  data_in = '0;
  logic [31:0] blocks_per_frame = '0;
  logic [15:0] estimated_noise;
  logic        estimated_noise_ready;

  int checks = 0;
  int errors = 0;
  int readyCount = 0;
  logic [15:0] readyValue;
  logic [7:0]  blkData [4];

  always #5 clk = ~clk;

  noise_estimation_top dut (
    .clk                  (clk),
    .rst                  (rst),
    .start_of_frame       (start_of_frame),
    .end_of_frame         (end_of_frame),
    .data_in              (data_in),
    .start_data           (start_data),
    .blocks_per_frame     (blocks_per_frame),
    .estimated_noise      (estimated_noise),
    .estimated_noise_ready(estimated_noise_ready)
  );

  // Every ready pulse is counted and its value captured, just after the edge that raised it.
  always @(posedge clk) begin
    #1;
    if (estimated_noise_ready === 1'b1) begin
      readyCount++;
      readyValue = estimated_noise;
    end
  end

  // Population variance of blkData using plain integer arithmetic.
  function automatic int refVar();
    int s = 0;
    int sq = 0;
    int mean;
    int v;
    for (int i = 0; i < 4; i++) begin
      int x = int'(blkData[i]);
      s  += x;
      sq += x * x;
    end
    mean = s / 4;
    v = sq / 4 - mean * mean;
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int refEstimate(input longint total, input int unsigned bpf);
    longint q;
    if (bpf == 0) return 0;
    q = total / longint'(bpf);
    return (q > 65535) ? 65535 : int'(q);
  endfunction

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one block (strobe + 4 samples) followed by the minimum 2-cycle gap.
  task automatic sendBlock(input logic sof, input logic eof);
    @(negedge clk);
    start_data     = 1'b1;
    start_of_frame = sof;
    end_of_frame   = eof;
    data_in        = blkData[0];
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      start_data     = 1'b0;
      start_of_frame = 1'b0;
      end_of_frame   = 1'b0;
      data_in        = blkData[i];
    end
    @(negedge clk);
    data_in = '0;
    @(negedge clk);
  endtask

  task automatic fillRamp(input int first);
    for (int i = 0; i < 4; i++) blkData[i] = 8'(first + 4 * i);
  endtask

  task automatic fillConst(input int v);
    for (int i = 0; i < 4; i++) blkData[i] = 8'(v);
  endtask

  task automatic fillAlt();
    blkData[0] = 8'd0; blkData[1] = 8'd255; blkData[2] = 8'd0; blkData[3] = 8'd255;
  endtask

  task automatic waitReady(input int baseline, output bit got);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (readyCount > baseline) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idleCycles(3);
    checks++;
    if (estimated_noise !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_estimate got %0d expected 0", estimated_noise);
    end
    checks++;
    if (estimated_noise_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready got %b expected 0", estimated_noise_ready);
    end
    rst = 1'b0;
    idleCycles(5);
    checks++;
    if (readyCount !== 0) begin
      errors++; $display("[TB] FAIL reset_no_pulse got %0d expected 0", readyCount);
    end
  endtask

  task automatic test_ramp_frame();
    longint total = 0;
    int base = readyCount;
    int expected;
    bit got;
    blocks_per_frame = 32'd4;
    for (int b = 0; b < 4; b++) begin
      fillRamp(4 + 16 * b);
      total += refVar();
      sendBlock(b == 0, b == 3);
    end
    expected = refEstimate(total, 4);
    waitReady(base, got);
    checks++;
    if (!got || readyValue !== 16'(expected)) begin
      errors++; $display("[TB] FAIL ramp_estimate got %0d expected %0d (ready seen %0d)", readyValue, expected, got);
    end
    idleCycles(20);
    checks++;
    if (readyCount !== base + 1) begin
      errors++; $display("[TB] FAIL ramp_pulse_count got %0d expected %0d", readyCount - base, 1);
    end
    checks++;
    if (estimated_noise !== 16'(expected)) begin
      errors++; $display("[TB] FAIL ramp_hold got %0d expected %0d", estimated_noise, expected);
    end
  endtask

  task automatic test_single_block(input string name, input int unsigned bpf, input int kind);
    int base = readyCount;
    int expected;
    bit got;
    blocks_per_frame = bpf;
    if (kind == 0) fillConst(7); else fillAlt();
    expected = refEstimate(longint'(refVar()), bpf);
    sendBlock(1'b1, 1'b1);
    waitReady(base, got);
    checks++;
    if (!got || readyValue !== 16'(expected)) begin
      errors++; $display("[TB] FAIL %s got %0d expected %0d (ready seen %0d)", name, readyValue, expected, got);
    end
  endtask

  task automatic test_floor();
    int base = readyCount;
    bit got;
    longint total;
    blocks_per_frame = 32'd2;
    fillRamp(4);
    total = refVar();
    sendBlock(1'b1, 1'b0);
    fillConst(9);
    total += refVar();
    sendBlock(1'b0, 1'b1);
    waitReady(base, got);
    checks++;
    if (!got || readyValue !== 16'(refEstimate(total, 2))) begin
      errors++; $display("[TB] FAIL floor_estimate got %0d expected %0d", readyValue, refEstimate(total, 2));
    end
  endtask

  task automatic test_bpf_zero();
    int base = readyCount;
    bit got;
    blocks_per_frame = 32'd0;
    fillRamp(40);
    sendBlock(1'b1, 1'b0);
    fillAlt();
    sendBlock(1'b0, 1'b1);
    waitReady(base, got);
    checks++;
    if (!got || readyValue !== 16'd0) begin
      errors++; $display("[TB] FAIL bpf_zero_estimate got %0d expected 0 (ready seen %0d)", readyValue, got);
    end
    idleCycles(60);
    checks++;
    if (readyCount !== base + 1) begin
      errors++; $display("[TB] FAIL bpf_zero_pulses got %0d expected 1", readyCount - base);
    end
  endtask

  task automatic test_saturation();
    int base = readyCount;
    bit got;
    longint total = 0;
    blocks_per_frame = 32'd1;
    fillAlt();
    for (int b = 0; b < 5; b++) begin
      total += refVar();
      sendBlock(b == 0, b == 4);
    end
    waitReady(base, got);
    checks++;
    if (!got || readyValue !== 16'(refEstimate(total, 1))) begin
      errors++; $display("[TB] FAIL saturation got %0d expected %0d", readyValue, refEstimate(total, 1));
    end
  endtask

  task automatic test_restart();
    int base = readyCount;
    bit got;
    int expected;
    blocks_per_frame = 32'd1;
    fillRamp(4);
    sendBlock(1'b1, 1'b0);
    fillAlt();
    expected = refEstimate(longint'(refVar()), 1);
    sendBlock(1'b1, 1'b1);
    waitReady(base, got);
    checks++;
    if (!got || readyValue !== 16'(expected)) begin
      errors++; $display("[TB] FAIL restart got %0d expected %0d", readyValue, expected);
    end
  endtask

  task automatic test_reset_divide();
    int base;
    bit got;
    longint total;
    blocks_per_frame = 32'd3;
    fillRamp(4);
    sendBlock(1'b1, 1'b1);
    idleCycles(10);
    base = readyCount;
    rst = 1'b1;
    idleCycles(2);
    checks++;
    if (estimated_noise !== 16'd0 || estimated_noise_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_divide_outputs got %0d/%b expected 0/0", estimated_noise, estimated_noise_ready);
    end
    rst = 1'b0;
    idleCycles(80);
    checks++;
    if (readyCount !== base) begin
      errors++; $display("[TB] FAIL reset_divide_no_pulse got %0d expected 0", readyCount - base);
    end
    blocks_per_frame = 32'd2;
    fillAlt();
    total = refVar();
    sendBlock(1'b1, 1'b0);
    fillRamp(100);
    total += refVar();
    sendBlock(1'b0, 1'b1);
    waitReady(base, got);
    checks++;
    if (!got || readyValue !== 16'(refEstimate(total, 2))) begin
      errors++; $display("[TB] FAIL reset_divide_recover got %0d expected %0d", readyValue, refEstimate(total, 2));
    end
  endtask

  task automatic test_ignored_strobe();
    int base = readyCount;
    bit got;
    int expected;
    blocks_per_frame = 32'd1;
    fillRamp(8);
    expected = refEstimate(longint'(refVar()), 1);
    sendBlock(1'b1, 1'b1);
    idleCycles(5);
    fillAlt();
    sendBlock(1'b1, 1'b1);
    waitReady(base, got);
    checks++;
    if (!got || readyValue !== 16'(expected)) begin
      errors++; $display("[TB] FAIL ignored_strobe got %0d expected %0d", readyValue, expected);
    end
    idleCycles(100);
    checks++;
    if (readyCount !== base + 1) begin
      errors++; $display("[TB] FAIL ignored_strobe_pulses got %0d expected 1", readyCount - base);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 8; f++) begin
      int base = readyCount;
      int nb = int'($urandom_range(1, 5));
      int unsigned bpf = $urandom_range(0, 6);
      longint total = 0;
      int expected;
      bit got;
      blocks_per_frame = bpf;
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 4; i++) blkData[i] = 8'($urandom_range(0, 255));
        total += refVar();
        sendBlock(b == 0, b == nb - 1);
      end
      expected = refEstimate(total, bpf);
      waitReady(base, got);
      checks++;
      if (!got || readyValue !== 16'(expected)) begin
        errors++; $display("[TB] FAIL random_frame_%0d got %0d expected %0d (blocks %0d bpf %0d)", f, readyValue, expected, nb, bpf);
      end
      idleCycles(3);
      checks++;
      if (readyCount !== base + 1) begin
        errors++; $display("[TB] FAIL random_pulses_%0d got %0d expected 1", f, readyCount - base);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_frame();
    test_single_block("constant_block", 32'd1, 0);
    test_floor();
    test_bpf_zero();
    test_saturation();
    test_restart();
    test_reset_divide();
    test_ignored_strobe();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
